// File: rtl/pm_clk_div_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pm_clk_div_bank_pkg                                         |
// | Description : Shared power-mode types and the mode -> divide-ratio helper |
// |               used by the power-mode clock divider bank.                  |
// | Contents    : powermode_t, pm_div_t, c_pm_div_max_w, mode_to_div()        |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package pm_clk_div_bank_pkg;

  typedef enum logic [1:0] {
    PM_SHUTDOWN = 2'd0,
    PM_LP       = 2'd1,
    PM_NORMAL   = 2'd2
  } powermode_t;

  // Widest divide counter any instance may use; instances slice this down.
  localparam int c_pm_div_max_w = 8;

  typedef logic [c_pm_div_max_w-1:0] pm_div_t;

  // Terminal count for a mode. SHUTDOWN has no running counter, so it maps to 0.
  function automatic pm_div_t mode_to_div(input powermode_t mode,
                                          input pm_div_t    lp_div,
                                          input pm_div_t    normal_div);
    pm_div_t div;
    case (mode)
      PM_LP:     div = lp_div;
      PM_NORMAL: div = normal_div;
      default:   div = '0;
    endcase
    return div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pm_clk_div_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pm_clk_div_bank_if                                          |
// | Description : Power-controller <-> clock-divider-bank bus.                |
// | Signals     : force_off  global shutdown override                         |
// |               req_valid  per-channel mode-change request                  |
// |               req_mode   requested mode per channel                       |
// |               req_ready  per-channel: no request pending                  |
// |               ack        per-channel one-cycle "new mode in effect"       |
// |               cur_mode   mode in effect per channel                       |
// |               oclk       divided output clocks                            |
// | Modports    : master (power controller), slave (divider bank)             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface pm_clk_div_bank_if
  import pm_clk_div_bank_pkg::*;
#(
  parameter int NCH = 4
);
  logic             force_off;
  logic [NCH-1:0]   req_valid;
  powermode_t       req_mode [NCH];
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   ack;
  powermode_t       cur_mode [NCH];
  logic [NCH-1:0]   oclk;

  modport master (
    output force_off, req_valid, req_mode,
    input  req_ready, ack, cur_mode, oclk
  );

  modport slave (
    input  force_off, req_valid, req_mode,
    output req_ready, ack, cur_mode, oclk
  );
endinterface
`default_nettype wire

// File: rtl/pm_clk_div_bank_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pm_clk_div_ch                                               |
// | Description : One power-mode clock divider channel: divide counter,       |
// |               output clock flop and glitch-free mode-change handshake.    |
// | Ports       : clk, rst        system clock, async active-high reset       |
// |               i_force_off     global shutdown override                    |
// |               i_req_valid     mode-change request                         |
// |               i_req_mode      requested mode                              |
// |               o_req_ready     1 = request can be accepted                 |
// |               o_ack           one-cycle pulse: pending mode now in effect |
// |               o_cur_mode      mode in effect                              |
// |               o_oclk          divided clock (registered)                  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pm_clk_div_ch
  import pm_clk_div_bank_pkg::*;
#(
  parameter int         CNT_W      = 4,
  parameter int         LP_DIV     = 1,
  parameter int         NORMAL_DIV = 0,
  parameter powermode_t RESET_MODE = PM_NORMAL
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_force_off,
  input  wire logic       i_req_valid,
  input  wire powermode_t i_req_mode,
  output logic            o_req_ready,
  output logic            o_ack,
  output powermode_t      o_cur_mode,
  output logic            o_oclk
);

  localparam pm_div_t c_lp_div     = pm_div_t'(LP_DIV);
  localparam pm_div_t c_normal_div = pm_div_t'(NORMAL_DIV);

  // r_mode is the programmed mode; r_off overlays SHUTDOWN while force_off
  // holds the channel down, so the programmed mode survives the override.
  powermode_t       r_mode;
  powermode_t       r_pend_mode;
  logic             r_pending;
  logic             r_off;
  logic             r_ack;
  logic             r_oclk;
  logic [CNT_W-1:0] r_cnt;

  powermode_t       w_eff_mode;
  logic [CNT_W-1:0] w_div;
  logic             w_at_div;
  logic             w_boundary;
  logic             w_accept;
  logic             w_apply;

  always_comb begin
    w_eff_mode = r_off ? PM_SHUTDOWN : r_mode;
    w_div      = CNT_W'(mode_to_div(w_eff_mode, c_lp_div, c_normal_div));
    w_at_div   = (r_cnt == w_div);
    // Safe switch points: the falling toggle, or any edge while stopped
    // (oclk is already low then).
    w_boundary = (w_eff_mode == PM_SHUTDOWN) || (w_at_div && r_oclk);
    w_accept   = i_req_valid && o_req_ready;
    // A pending request is never applied while the override is active; it
    // lands on the first edge after force_off drops (channel is stopped then).
    w_apply    = r_pending && !i_force_off && w_boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= RESET_MODE;
      r_pend_mode <= RESET_MODE;
      r_pending   <= 1'b0;
      r_off       <= 1'b0;
      r_ack       <= 1'b0;
      r_oclk      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_ack <= w_apply;

      // accept and apply are mutually exclusive: accept needs !r_pending.
      if (w_accept) begin
        r_pend_mode <= i_req_mode;
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending   <= 1'b0;
      end

      if (w_boundary) begin
        r_cnt  <= '0;
        r_oclk <= 1'b0;
        r_off  <= i_force_off;
        if (w_apply) begin
          r_mode <= r_pend_mode;
        end
      end else if (w_at_div) begin
        // Not a boundary, so oclk is low here: this is the rising toggle.
        r_cnt  <= '0;
        r_oclk <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_req_ready = !r_pending && !i_force_off;
  assign o_ack       = r_ack;
  assign o_cur_mode  = w_eff_mode;
  assign o_oclk      = r_oclk;

endmodule
`default_nettype wire

// File: rtl/pm_clk_div_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pm_clk_div_bank                                             |
// | Description : Multi-channel power-mode clock divider. NCH independent     |
// |               channels, each dividing clk by a ratio chosen by its mode;  |
// |               force_off is fanned out to every channel.                   |
// | Ports       : clk   system clock                                          |
// |               rst   asynchronous active-high reset                        |
// |               bus   pm_clk_div_bank_if.slave (requests, acks, clocks)     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pm_clk_div_bank
  import pm_clk_div_bank_pkg::*;
#(
  parameter int         NCH        = 4,
  parameter int         CNT_W      = 4,
  parameter int         LP_DIV     = 1,
  parameter int         NORMAL_DIV = 0,
  parameter powermode_t RESET_MODE = PM_NORMAL
) (
  input wire logic          clk,
  input wire logic          rst,
  pm_clk_div_bank_if.slave  bus
);

  generate
    if (CNT_W > c_pm_div_max_w || LP_DIV >= (1 << CNT_W) ||
        NORMAL_DIV >= (1 << CNT_W)) begin : g_param_err
      $error("pm_clk_div_bank: divide ratio does not fit CNT_W");
    end
  endgenerate

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      pm_clk_div_ch #(
        .CNT_W      (CNT_W),
        .LP_DIV     (LP_DIV),
        .NORMAL_DIV (NORMAL_DIV),
        .RESET_MODE (RESET_MODE)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .i_force_off (bus.force_off),
        .i_req_valid (bus.req_valid[g]),
        .i_req_mode  (bus.req_mode[g]),
        .o_req_ready (bus.req_ready[g]),
        .o_ack       (bus.ack[g]),
        .o_cur_mode  (bus.cur_mode[g]),
        .o_oclk      (bus.oclk[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pm_clk_div_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pm_clk_div_bank                                          |
// | Description : Self-checking bench for pm_clk_div_bank (NCH=2, LP_DIV=1,   |
// |               NORMAL_DIV=0). Table of per-edge vectors for reset/NORMAL/  |
// |               LP switching, then hand sequences for the corner cases.     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pm_clk_div_bank;
  import pm_clk_div_bank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pm_clk_div_bank_if #(.NCH(2)) bif ();

  pm_clk_div_bank #(
    .NCH(2), .CNT_W(4), .LP_DIV(1), .NORMAL_DIV(0), .RESET_MODE(PM_NORMAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [1:0] vld;
    powermode_t m0;
    logic [1:0] oclk;
    logic [1:0] ack;
    logic [1:0] rdy;
    powermode_t e0;
    powermode_t e1;
  } vec_t;

  vec_t tbl [20];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] vld, input powermode_t m0, input logic [1:0] oclk,
                              input logic [1:0] ack, input logic [1:0] rdy,
                              input powermode_t e0, input powermode_t e1);
    vec_t v;
    v.vld = vld; v.m0 = m0; v.oclk = oclk; v.ack = ack; v.rdy = rdy; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk_all(input string tag, input logic [1:0] oclk, input logic [1:0] ack,
                         input logic [1:0] rdy, input powermode_t e0, input powermode_t e1);
    chk({tag, " oclk"},  32'(bif.oclk), 32'(oclk));
    chk({tag, " ack"},   32'(bif.ack), 32'(ack));
    chk({tag, " ready"}, 32'(bif.req_ready), 32'(rdy));
    chk({tag, " mode"},  32'({bif.cur_mode[1], bif.cur_mode[0]}), 32'({e1, e0}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int         got;
    int         n_ack;

    bif.force_off   = 1'b0;
    bif.req_valid   = 2'b00;
    bif.req_mode[0] = PM_NORMAL;
    bif.req_mode[1] = PM_NORMAL;

    // Edges 1..20 after reset release. NORMAL toggles every edge; ch0 asks
    // for LP at edge 10, switches at the falling toggle of edge 12.
    tbl[0]  = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[1]  = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[2]  = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[3]  = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[4]  = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[5]  = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[6]  = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[7]  = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[8]  = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tbl[9]  = mk(2'b01, PM_LP,     2'b00, 2'b00, 2'b10, PM_NORMAL, PM_NORMAL);
    tbl[10] = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b10, PM_NORMAL, PM_NORMAL);
    tbl[11] = mk(2'b00, PM_NORMAL, 2'b00, 2'b01, 2'b11, PM_LP,     PM_NORMAL);
    tbl[12] = mk(2'b00, PM_NORMAL, 2'b10, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[13] = mk(2'b00, PM_NORMAL, 2'b01, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[14] = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[15] = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[16] = mk(2'b00, PM_NORMAL, 2'b10, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[17] = mk(2'b00, PM_NORMAL, 2'b01, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[18] = mk(2'b00, PM_NORMAL, 2'b11, 2'b00, 2'b11, PM_LP,     PM_NORMAL);
    tbl[19] = mk(2'b00, PM_NORMAL, 2'b00, 2'b00, 2'b11, PM_LP,     PM_NORMAL);

    // Test 1: reset values, held and just after release.
    repeat (3) tick();
    chk_all("rst held", 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    rst = 1'b0;
    #1;
    chk_all("rst released", 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);

    // Tests 1-2: table-driven edges.
    for (int i = 0; i < 20; i++) begin
      bif.req_valid   = tbl[i].vld;
      bif.req_mode[0] = tbl[i].m0;
      tick();
      chk_all($sformatf("edge%0d", i + 1), tbl[i].oclk, tbl[i].ack, tbl[i].rdy, tbl[i].e0, tbl[i].e1);
    end
    bif.req_valid = 2'b00;

    // Test 3: LP high phase completes at full width before SHUTDOWN.
    tick();
    chk("t3 pre low", 32'(bif.oclk[0]), 32'd0);
    tick();
    chk("t3 just rose", 32'(bif.oclk[0]), 32'd1);
    bif.req_valid   = 2'b01;
    bif.req_mode[0] = PM_SHUTDOWN;
    tick();
    bif.req_valid = 2'b00;
    chk("t3 high 2nd cycle", 32'(bif.oclk[0]), 32'd1);
    chk("t3 no early ack", 32'(bif.ack[0]), 32'd0);
    chk("t3 ready low", 32'(bif.req_ready[0]), 32'd0);
    tick();
    chk("t3 fell", 32'(bif.oclk[0]), 32'd0);
    chk("t3 ack", 32'(bif.ack[0]), 32'd1);
    chk("t3 mode", 32'(bif.cur_mode[0]), 32'(PM_SHUTDOWN));
    n_ack = 0;
    got   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_ack += int'(bif.ack[0]);
      got   += int'(bif.oclk[0]);
    end
    chk("t3 stays low", 32'(got), 32'd0);
    chk("t3 single ack", 32'(n_ack), 32'd0);

    // Test 4: ch1 SHUTDOWN -> NORMAL takes effect on the very next edge.
    bif.req_valid   = 2'b10;
    bif.req_mode[1] = PM_SHUTDOWN;
    tick();
    bif.req_valid = 2'b00;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      tick();
      if (bif.ack[1]) got = 1;
    end
    chk("t4 ch1 shutdown ack seen", 32'(got), 32'd1);
    chk("t4 ch1 shutdown mode", 32'(bif.cur_mode[1]), 32'(PM_SHUTDOWN));
    tick();
    bif.req_valid   = 2'b10;
    bif.req_mode[1] = PM_NORMAL;
    tick();
    bif.req_valid = 2'b00;
    chk("t4 k mode", 32'(bif.cur_mode[1]), 32'(PM_SHUTDOWN));
    chk("t4 k ack", 32'(bif.ack[1]), 32'd0);
    tick();
    chk("t4 k+1 mode", 32'(bif.cur_mode[1]), 32'(PM_NORMAL));
    chk("t4 k+1 ack", 32'(bif.ack[1]), 32'd1);
    chk("t4 k+1 oclk", 32'(bif.oclk[1]), 32'd0);
    tick();
    chk("t4 k+2 oclk", 32'(bif.oclk[1]), 32'd1);
    chk("t4 k+2 ack", 32'(bif.ack[1]), 32'd0);

    // Test 5: second request while busy is dropped.
    bif.req_valid   = 2'b01;
    bif.req_mode[0] = PM_LP;
    tick();
    chk("t5 ready after accept", 32'(bif.req_ready[0]), 32'd0);
    chk("t5 still shutdown", 32'(bif.cur_mode[0]), 32'(PM_SHUTDOWN));
    bif.req_mode[0] = PM_NORMAL;
    tick();
    bif.req_valid = 2'b00;
    n_ack = int'(bif.ack[0]);
    chk("t5 LP applied", 32'(bif.cur_mode[0]), 32'(PM_LP));
    chk("t5 oclk start", 32'(bif.oclk[0]), 32'd0);
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_ack += int'(bif.ack[0]);
      chk($sformatf("t5 LP oclk %0d", i), 32'(bif.oclk[0]), 32'(pat[i]));
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_ack += int'(bif.ack[0]);
    end
    chk("t5 single ack", 32'(n_ack), 32'd1);
    chk("t5 mode kept", 32'(bif.cur_mode[0]), 32'(PM_LP));

    // Test 6: force_off with ch0 pending LP.
    bif.req_valid   = 2'b01;
    bif.req_mode[0] = PM_LP;
    tick();
    bif.req_valid = 2'b00;
    chk("t6 pending", 32'(bif.req_ready[0]), 32'd0);
    bif.force_off = 1'b1;
    n_ack = 0;
    got   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_ack += int'(bif.ack != 2'b00);
      got   += int'(bif.req_ready != 2'b00);
    end
    chk("t6 no ack", 32'(n_ack), 32'd0);
    chk("t6 ready low", 32'(got), 32'd0);
    chk_all("t6 forced", 2'b00, 2'b00, 2'b00, PM_SHUTDOWN, PM_SHUTDOWN);
    bif.force_off = 1'b0;
    tick();
    chk_all("t6 release", 2'b00, 2'b01, 2'b11, PM_LP, PM_NORMAL);
    tick();
    chk("t6 resume oclk", 32'(bif.oclk), 32'(2'b10));
    chk("t6 resume ack", 32'(bif.ack), 32'(2'b00));

    // Reset mid-pending discards the request.
    bif.req_valid   = 2'b01;
    bif.req_mode[0] = PM_SHUTDOWN;
    tick();
    bif.req_valid = 2'b00;
    chk("t6 rst pending", 32'(bif.req_ready[0]), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk_all("t6 async rst", 2'b00, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all("t6 post rst", 2'b11, 2'b00, 2'b11, PM_NORMAL, PM_NORMAL);
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_ack += int'(bif.ack[0]);
    end
    chk("t6 discarded ack", 32'(n_ack), 32'd0);
    chk("t6 discarded mode", 32'(bif.cur_mode[0]), 32'(PM_NORMAL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
